sig_head_monitor: RTL and testbench

- Consumer end of the highway/country light-code interface: samples the 2-bit `hwy` and `cntry` codes driven by the signal controller and decodes them into one-hot lamp drives for each signal head.
- Acts as an independent conflict monitor. It checks code validity, mutual exclusion, legal colour sequence and minimum yellow time.
- On any violation it latches a fault and forces both heads to flashing red until reset.

---
 rtl/sig_head_monitor.sv | 173 +++++++++++++++++
 tb/tb_sig_head_monitor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sig_head_monitor.sv
// rtl/sig_head_monitor.sv - signal head lamp decoder with independent conflict monitor
// Decodes highway/country light codes into lamp drives and latches a flashing-red fault on any violation.
module sig_head_monitor #(
   parameter int START_CYCLES = 4,
   parameter int MIN_YELLOW   = 3,
   parameter int FLASH_HALF   = 4
) (
   input  logic       clock,
   input  logic       clear_n,
   input  logic [1:0] hwy,
   input  logic [1:0] cntry,
   output logic [2:0] hwy_lamp,
   output logic [2:0] cntry_lamp,
   output logic       fault,
   output logic [2:0] fault_code
);

   typedef enum logic [1:0] {ST_START, ST_RUN, ST_FLASH} state_t;

   localparam logic [1:0] C_RED    = 2'd0;
   localparam logic [1:0] C_YELLOW = 2'd1;
   localparam logic [1:0] C_GREEN  = 2'd2;
   localparam logic [1:0] C_BAD    = 2'd3;
   localparam logic [2:0] L_RED    = 3'b100;
   localparam logic [2:0] L_OFF    = 3'b000;

   state_t     state_q, state_d;
   logic [7:0] start_cnt_q, start_cnt_d;
   logic [7:0] flash_cnt_q, flash_cnt_d;
   logic       flash_ph_q, flash_ph_d;
   logic [1:0] prev_hwy_q, prev_hwy_d;
   logic [1:0] prev_cntry_q, prev_cntry_d;
   logic [7:0] hwy_ycnt_q, hwy_ycnt_d;
   logic [7:0] cntry_ycnt_q, cntry_ycnt_d;
   logic [2:0] hwy_lamp_q, hwy_lamp_d;
   logic [2:0] cntry_lamp_q, cntry_lamp_d;
   logic       fault_q, fault_d;
   logic [2:0] fault_code_q, fault_code_d;

   logic [7:0] hwy_ycnt_nx, cntry_ycnt_nx;
   logic [2:0] code;

   function automatic logic [2:0] decode(input logic [1:0] c);
      case (c)
         C_RED:    decode = 3'b100;
         C_YELLOW: decode = 3'b010;
         C_GREEN:  decode = 3'b001;
         default:  decode = 3'b100;
      endcase
   endfunction

   function automatic logic legal_step(input logic [1:0] p, input logic [1:0] c);
      legal_step = (p == c) ||
                   (p == C_GREEN  && c == C_YELLOW) ||
                   (p == C_YELLOW && c == C_RED) ||
                   (p == C_RED    && c == C_GREEN);
   endfunction

   function automatic logic [7:0] ycnt_next(input logic [1:0] c, input logic [7:0] cnt);
      if (c != C_YELLOW)    ycnt_next = 8'd0;
      else if (cnt == 8'hFF) ycnt_next = cnt;
      else                   ycnt_next = cnt + 8'd1;
   endfunction

   always_comb begin
      state_d       = state_q;
      start_cnt_d   = start_cnt_q;
      flash_cnt_d   = flash_cnt_q;
      flash_ph_d    = flash_ph_q;
      prev_hwy_d    = prev_hwy_q;
      prev_cntry_d  = prev_cntry_q;
      hwy_ycnt_d    = hwy_ycnt_q;
      cntry_ycnt_d  = cntry_ycnt_q;
      hwy_lamp_d    = hwy_lamp_q;
      cntry_lamp_d  = cntry_lamp_q;
      fault_d       = fault_q;
      fault_code_d  = fault_code_q;
      hwy_ycnt_nx   = ycnt_next(hwy, hwy_ycnt_q);
      cntry_ycnt_nx = ycnt_next(cntry, cntry_ycnt_q);
      code          = 3'd0;

      // Lowest fault code wins, so check in priority order
      if (hwy == C_BAD || cntry == C_BAD)
         code = 3'd1;
      else if (hwy != C_RED && cntry != C_RED)
         code = 3'd2;
      else if (!legal_step(prev_hwy_q, hwy) || !legal_step(prev_cntry_q, cntry))
         code = 3'd3;
      else if ((prev_hwy_q == C_YELLOW && hwy == C_RED && hwy_ycnt_q < 8'(MIN_YELLOW)) ||
               (prev_cntry_q == C_YELLOW && cntry == C_RED && cntry_ycnt_q < 8'(MIN_YELLOW)))
         code = 3'd4;

      case (state_q)
         ST_START: begin
            hwy_lamp_d   = L_RED;
            cntry_lamp_d = L_RED;
            prev_hwy_d   = hwy;
            prev_cntry_d = cntry;
            hwy_ycnt_d   = hwy_ycnt_nx;
            cntry_ycnt_d = cntry_ycnt_nx;
            if (start_cnt_q == 8'(START_CYCLES - 1))
               state_d = ST_RUN;
            else
               start_cnt_d = start_cnt_q + 8'd1;
         end
         ST_RUN: begin
            if (code != 3'd0) begin
               state_d      = ST_FLASH;
               fault_d      = 1'b1;
               fault_code_d = code;
               hwy_lamp_d   = L_RED;
               cntry_lamp_d = L_RED;
               flash_cnt_d  = 8'd0;
               flash_ph_d   = 1'b1;
            end else begin
               hwy_lamp_d   = decode(hwy);
               cntry_lamp_d = decode(cntry);
               prev_hwy_d   = hwy;
               prev_cntry_d = cntry;
               hwy_ycnt_d   = hwy_ycnt_nx;
               cntry_ycnt_d = cntry_ycnt_nx;
            end
         end
         ST_FLASH: begin
            if (flash_cnt_q == 8'(FLASH_HALF - 1)) begin
               flash_cnt_d = 8'd0;
               flash_ph_d  = ~flash_ph_q;
            end else begin
               flash_cnt_d = flash_cnt_q + 8'd1;
            end
            hwy_lamp_d   = flash_ph_d ? L_RED : L_OFF;
            cntry_lamp_d = flash_ph_d ? L_RED : L_OFF;
         end
         default: state_d = ST_START;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state_q      <= ST_START;
         start_cnt_q  <= 8'd0;
         flash_cnt_q  <= 8'd0;
         flash_ph_q   <= 1'b1;
         prev_hwy_q   <= C_RED;
         prev_cntry_q <= C_RED;
         hwy_ycnt_q   <= 8'd0;
         cntry_ycnt_q <= 8'd0;
         hwy_lamp_q   <= L_RED;
         cntry_lamp_q <= L_RED;
         fault_q      <= 1'b0;
         fault_code_q <= 3'd0;
      end else begin
         state_q      <= state_d;
         start_cnt_q  <= start_cnt_d;
         flash_cnt_q  <= flash_cnt_d;
         flash_ph_q   <= flash_ph_d;
         prev_hwy_q   <= prev_hwy_d;
         prev_cntry_q <= prev_cntry_d;
         hwy_ycnt_q   <= hwy_ycnt_d;
         cntry_ycnt_q <= cntry_ycnt_d;
         hwy_lamp_q   <= hwy_lamp_d;
         cntry_lamp_q <= cntry_lamp_d;
         fault_q      <= fault_d;
         fault_code_q <= fault_code_d;
      end
   end

   assign hwy_lamp   = hwy_lamp_q;
   assign cntry_lamp = cntry_lamp_q;
   assign fault      = fault_q;
   assign fault_code = fault_code_q;

endmodule

// File: tb/tb_sig_head_monitor.sv
// tb/tb_sig_head_monitor.sv - self-checking bench for sig_head_monitor
// Directed and randomized steps compared against a history-based reference model.
module tb_sig_head_monitor;

   localparam int START_CYCLES = 4;
   localparam int MIN_YELLOW   = 3;
   localparam int FLASH_HALF   = 4;

   logic       clock = 1'b0;
   logic       clear_n = 1'b0;
   logic [1:0] hwy = 2'd0;
   logic [1:0] cntry = 2'd0;
   logic [2:0] hwy_lamp, cntry_lamp, fault_code;
   logic       fault;

   int checks = 0;
   int errors = 0;

   // reference model state: edges since reset, accepted code history, fault record
   int n_edge;
   int m_fault;
   int m_code;
   int f_edge;
   int hq[$];
   int cq[$];
   int exp_hl, exp_cl;

   sig_head_monitor #(
      .START_CYCLES(START_CYCLES),
      .MIN_YELLOW(MIN_YELLOW),
      .FLASH_HALF(FLASH_HALF)
   ) dut (
      .clock(clock),
      .clear_n(clear_n),
      .hwy(hwy),
      .cntry(cntry),
      .hwy_lamp(hwy_lamp),
      .cntry_lamp(cntry_lamp),
      .fault(fault),
      .fault_code(fault_code)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, n_edge);
      end
   endtask

   function automatic int lamp_of(input int code);
      return (code == 0) ? 4 : (code == 1) ? 2 : (code == 2) ? 1 : -1;
   endfunction

   function automatic bit step_ok(input int p, input int c);
      int nxt;
      nxt = (p == 2) ? 1 : (p == 1) ? 0 : (p == 0) ? 2 : -1;
      return (c == p) || (c == nxt);
   endfunction

   function automatic int yellow_run(input int q[$]);
      int r = 0;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i] != 1) break;
         r++;
      end
      return (r > 255) ? 255 : r;
   endfunction

   task automatic model_reset();
      n_edge  = 0;
      m_fault = 0;
      m_code  = 0;
      f_edge  = 0;
      hq.delete();
      cq.delete();
      exp_hl  = 4;
      exp_cl  = 4;
   endtask

   task automatic model_edge(input int h, input int c);
      int ph, pc, code;
      n_edge++;
      if (m_fault != 0) begin
         exp_hl = (((n_edge - f_edge) / FLASH_HALF) % 2 == 0) ? 4 : 0;
         exp_cl = exp_hl;
      end else if (n_edge <= START_CYCLES) begin
         exp_hl = 4;
         exp_cl = 4;
         hq.push_back(h);
         cq.push_back(c);
      end else begin
         ph = (hq.size() == 0) ? 0 : hq[hq.size() - 1];
         pc = (cq.size() == 0) ? 0 : cq[cq.size() - 1];
         code = 0;
         if (h == 3 || c == 3) code = 1;
         else if (h != 0 && c != 0) code = 2;
         else if (!step_ok(ph, h) || !step_ok(pc, c)) code = 3;
         else if ((ph == 1 && h == 0 && yellow_run(hq) < MIN_YELLOW) ||
                  (pc == 1 && c == 0 && yellow_run(cq) < MIN_YELLOW)) code = 4;
         if (code != 0) begin
            m_fault = 1;
            m_code  = code;
            f_edge  = n_edge;
            exp_hl  = 4;
            exp_cl  = 4;
         end else begin
            exp_hl = lamp_of(h);
            exp_cl = lamp_of(c);
            hq.push_back(h);
            cq.push_back(c);
         end
      end
   endtask

   task automatic check_outputs();
      chk("hwy_lamp",   8'(hwy_lamp),   8'(exp_hl));
      chk("cntry_lamp", 8'(cntry_lamp), 8'(exp_cl));
      chk("fault",      8'(fault),      8'(m_fault));
      chk("fault_code", 8'(fault_code), 8'(m_code));
   endtask

   task automatic do_reset(input logic [1:0] h, input logic [1:0] c);
      clear_n = 1'b0;
      hwy = h;
      cntry = c;
      @(posedge clock);
      model_reset();
      #1;
      check_outputs();
      clear_n = 1'b1;
   endtask

   task automatic step(input logic [1:0] h, input logic [1:0] c);
      hwy = h;
      cntry = c;
      @(posedge clock);
      model_edge(int'(h), int'(c));
      #1;
      check_outputs();
   endtask

   logic [1:0] gh, gc;

   initial begin
      // power-up and basic start window; reset beats an invalid code at the same edge
      do_reset(2'd3, 2'd2);
      repeat (4) step(2'd2, 2'd0);
      repeat (2) step(2'd2, 2'd0);
      // legal cycle with exact minimum yellow
      repeat (3) step(2'd1, 2'd0);
      step(2'd0, 2'd0);
      repeat (2) step(2'd0, 2'd2);
      repeat (4) step(2'd0, 2'd1);
      step(2'd0, 2'd0);
      // yellow too short, then watch the flash
      step(2'd2, 2'd0);
      repeat (2) step(2'd1, 2'd0);
      step(2'd0, 2'd0);
      repeat (12) step(2'd0, 2'd0);

      // conflict
      do_reset(2'd0, 2'd0);
      repeat (4) step(2'd0, 2'd0);
      step(2'd2, 2'd2);
      repeat (3) step(2'd0, 2'd0);

      // invalid code and conflict together
      do_reset(2'd0, 2'd0);
      repeat (4) step(2'd0, 2'd0);
      step(2'd3, 2'd2);
      repeat (3) step(2'd0, 2'd0);

      // illegal hop, then legal codes ignored while flashing
      do_reset(2'd0, 2'd0);
      repeat (5) step(2'd2, 2'd0);
      step(2'd0, 2'd0);
      repeat (3) begin
         step(2'd2, 2'd0);
         repeat (3) step(2'd1, 2'd0);
         step(2'd0, 2'd0);
      end

      // one-cycle reset from flash, normal decode returns after the start window
      do_reset(2'd2, 2'd0);
      repeat (4) step(2'd2, 2'd0);
      repeat (2) step(2'd2, 2'd0);
      step(2'd1, 2'd0);

      // randomized episodes: mostly a plausible controller, occasionally arbitrary codes
      for (int ep = 0; ep < 30; ep++) begin
         do_reset(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         gh = 2'd0;
         gc = 2'd0;
         for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 99) < 4) begin
               gh = 2'($urandom_range(0, 3));
               gc = 2'($urandom_range(0, 3));
            end else if ($urandom_range(0, 99) < 35) begin
               if (gh == 2'd2) gh = 2'd1;
               else if (gh == 2'd1) gh = 2'd0;
               else if (gc == 2'd2) gc = 2'd1;
               else if (gc == 2'd1) gc = 2'd0;
               else if (gh == 2'd0 && gc == 2'd0) begin
                  if ($urandom_range(0, 1) == 0) gh = 2'd2;
                  else gc = 2'd2;
               end else begin
                  gh = 2'd0;
                  gc = 2'd0;
               end
            end
            step(gh, gc);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
